// File: rtl/alu_pkg.sv
// Shared ALU encodings: operation codes, R-type funct codes, ALUOp classes
// and immediate sub-codes. Used by the ALU control decoder and the ALU.
package alu_pkg;

  // ALU operation codes. 4'b1110 and 4'b1111 are unused.
  typedef enum logic [3:0] {
    OP_SLL  = 4'b0000,
    OP_SRL  = 4'b0001,
    OP_SRA  = 4'b0010,
    OP_ADD  = 4'b0011,
    OP_SUB  = 4'b0100,
    OP_AND  = 4'b0101,
    OP_OR   = 4'b0110,
    OP_XOR  = 4'b0111,
    OP_NOR  = 4'b1000,
    OP_SLT  = 4'b1001,
    OP_LUI  = 4'b1010,
    OP_SLLV = 4'b1011,
    OP_SRLV = 4'b1100,
    OP_SRAV = 4'b1101
  } alu_op_e;

  // Operation classes issued by the main control unit.
  localparam logic [3:0] ALUOP_RTYPE  = 4'b0000;
  localparam logic [3:0] ALUOP_MEM    = 4'b0001;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0100;

  // R-type funct field encodings.
  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU = 6'b100001;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU = 6'b100011;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_XOR  = 6'b100110;
  localparam logic [5:0] FUNCT_NOR  = 6'b100111;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;

  // Immediate sub-codes carried in ALUOp[2:0] when ALUOp[3] is set.
  localparam logic [2:0] IMM_ADD = 3'b000;
  localparam logic [2:0] IMM_SLT = 3'b010;
  localparam logic [2:0] IMM_AND = 3'b100;
  localparam logic [2:0] IMM_OR  = 3'b101;
  localparam logic [2:0] IMM_XOR = 3'b110;
  localparam logic [2:0] IMM_LUI = 3'b111;

  // One decode result: operation plus unsupported-encoding flag.
  typedef struct packed {
    alu_op_e op;
    logic    illegal;
  } decode_t;

  // Unsupported encodings fall back to ADD with the illegal flag raised.
  localparam decode_t DECODE_ILLEGAL = '{op: OP_ADD, illegal: 1'b1};
  localparam decode_t DECODE_RESET   = '{op: OP_ADD, illegal: 1'b0};

  // Decode an immediate-class sub-code; 001 and 011 are unsupported.
  function automatic decode_t decode_imm(input logic [2:0] sub);
    decode_t d;
    d = DECODE_ILLEGAL;
    case (sub)
      IMM_ADD: d = '{op: OP_ADD, illegal: 1'b0};
      IMM_SLT: d = '{op: OP_SLT, illegal: 1'b0};
      IMM_AND: d = '{op: OP_AND, illegal: 1'b0};
      IMM_OR:  d = '{op: OP_OR,  illegal: 1'b0};
      IMM_XOR: d = '{op: OP_XOR, illegal: 1'b0};
      IMM_LUI: d = '{op: OP_LUI, illegal: 1'b0};
      default: d = DECODE_ILLEGAL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_control_if.sv
// Bus between main control and the ALU control decoder: operation class and
// funct field in, registered ALU operation and illegal flag out.
interface alu_control_if;
  logic [3:0] i_ALUOp;
  logic [5:0] i_funct;
  logic [3:0] o_operation;
  logic       o_illegal;

  // Main-control side: drives the request, observes the decode.
  modport master (
    output i_ALUOp,
    output i_funct,
    input  o_operation,
    input  o_illegal
  );

  // Decoder side: consumes the request, drives the decode.
  modport slave (
    input  i_ALUOp,
    input  i_funct,
    output o_operation,
    output o_illegal
  );
endinterface

// File: rtl/alu_funct_decode.sv
// Combinational R-type funct decoder. Unknown functs map to ADD and raise
// the illegal flag.
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] i_funct,
  output alu_op_e    o_operation,
  output logic       o_illegal
);

  // Map each supported funct to its ALU operation.
  always_comb begin
    o_operation = OP_ADD;
    o_illegal   = 1'b0;
    case (i_funct)
      FUNCT_ADD,
      FUNCT_ADDU: o_operation = OP_ADD;
      FUNCT_SUB,
      FUNCT_SUBU: o_operation = OP_SUB;
      FUNCT_AND:  o_operation = OP_AND;
      FUNCT_OR:   o_operation = OP_OR;
      FUNCT_XOR:  o_operation = OP_XOR;
      FUNCT_NOR:  o_operation = OP_NOR;
      FUNCT_SLT:  o_operation = OP_SLT;
      FUNCT_SLL:  o_operation = OP_SLL;
      FUNCT_SRL:  o_operation = OP_SRL;
      FUNCT_SRA:  o_operation = OP_SRA;
      FUNCT_SLLV: o_operation = OP_SLLV;
      FUNCT_SRLV: o_operation = OP_SRLV;
      FUNCT_SRAV: o_operation = OP_SRAV;
      default: begin
        o_operation = OP_ADD;
        o_illegal   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_control.sv
// ALU control: selects the ALU operation from the operation class and, for
// R-type instructions, the funct field. Result is registered, one cycle
// latency, new decode every cycle.
module alu_control
  import alu_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst,
  alu_control_if.slave bus
);

  alu_op_e funct_op;
  logic    funct_illegal;
  decode_t decode_next;
  decode_t decode_reg;

  alu_funct_decode u_funct_decode (
    .i_funct     (bus.i_funct),
    .o_operation (funct_op),
    .o_illegal   (funct_illegal)
  );

  // Operation-class mux. Only the R-type branch looks at the funct field, so
  // an undriven funct cannot disturb any other class.
  always_comb begin
    decode_next = DECODE_ILLEGAL;
    casez (bus.i_ALUOp)
      ALUOP_RTYPE:  decode_next = '{op: funct_op, illegal: funct_illegal};
      ALUOP_MEM:    decode_next = '{op: OP_ADD, illegal: 1'b0};
      ALUOP_BRANCH: decode_next = '{op: OP_SUB, illegal: 1'b0};
      4'b1???:      decode_next = decode_imm(bus.i_ALUOp[2:0]);
      default:      decode_next = DECODE_ILLEGAL;
    endcase
  end

  // Output register; reset wins over the decode in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      decode_reg <= DECODE_RESET;
    end else begin
      decode_reg <= decode_next;
    end
  end

  assign bus.o_operation = decode_reg.op;
  assign bus.o_illegal   = decode_reg.illegal;

endmodule

// File: tb/tb_alu_control.sv
// Directed testbench for alu_control: reset, R-type sweep, load/store and
// branch, immediates, illegal encodings, hold/latency and mid-stream reset.
module tb_alu_control;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_control_if bus ();

  alu_control dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // R-type table: funct and the hand-computed operation code.
  logic [5:0] rt_funct [15];
  logic [3:0] rt_op    [15];

  // Immediate table: ALUOp and expected operation code.
  logic [3:0] im_aluop [6];
  logic [3:0] im_op    [6];

  initial begin
    rt_funct[0]  = 6'b100000; rt_op[0]  = 4'b0011;
    rt_funct[1]  = 6'b100001; rt_op[1]  = 4'b0011;
    rt_funct[2]  = 6'b100010; rt_op[2]  = 4'b0100;
    rt_funct[3]  = 6'b100011; rt_op[3]  = 4'b0100;
    rt_funct[4]  = 6'b100100; rt_op[4]  = 4'b0101;
    rt_funct[5]  = 6'b100101; rt_op[5]  = 4'b0110;
    rt_funct[6]  = 6'b100110; rt_op[6]  = 4'b0111;
    rt_funct[7]  = 6'b100111; rt_op[7]  = 4'b1000;
    rt_funct[8]  = 6'b101010; rt_op[8]  = 4'b1001;
    rt_funct[9]  = 6'b000000; rt_op[9]  = 4'b0000;
    rt_funct[10] = 6'b000010; rt_op[10] = 4'b0001;
    rt_funct[11] = 6'b000011; rt_op[11] = 4'b0010;
    rt_funct[12] = 6'b000100; rt_op[12] = 4'b1011;
    rt_funct[13] = 6'b000110; rt_op[13] = 4'b1100;
    rt_funct[14] = 6'b000111; rt_op[14] = 4'b1101;
    im_aluop[0] = 4'b1000; im_op[0] = 4'b0011;
    im_aluop[1] = 4'b1100; im_op[1] = 4'b0101;
    im_aluop[2] = 4'b1101; im_op[2] = 4'b0110;
    im_aluop[3] = 4'b1110; im_op[3] = 4'b0111;
    im_aluop[4] = 4'b1111; im_op[4] = 4'b1010;
    im_aluop[5] = 4'b1010; im_op[5] = 4'b1001;
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; bus.i_ALUOp = 4'b0000; bus.i_funct = 6'b100111;
    @(posedge clk); #1;
    checks++;
    if (bus.o_operation !== 4'b0011 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset: got op=%b ill=%b, expected op=0011 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("reset: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
    // First decode appears one edge after reset deasserts.
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.o_operation !== 4'b1000 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got op=%b ill=%b, expected op=1000 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("reset_release: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
  endtask

  task automatic test_rtype();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      bus.i_ALUOp = 4'b0000; bus.i_funct = rt_funct[i];
      @(posedge clk); #1;
      checks++;
      if (bus.o_operation !== rt_op[i] || bus.o_illegal !== 1'b0) begin
        errors++;
        $display("FAIL rtype funct=%b: got op=%b ill=%b, expected op=%b ill=0",
                 rt_funct[i], bus.o_operation, bus.o_illegal, rt_op[i]);
      end else begin
        $display("rtype funct=%b: op=%b ill=%b", rt_funct[i], bus.o_operation, bus.o_illegal);
      end
    end
  endtask

  task automatic test_mem_branch();
    @(negedge clk);
    bus.i_ALUOp = 4'b0001; bus.i_funct = 6'b100010;
    @(posedge clk); #1;
    checks++;
    if (bus.o_operation !== 4'b0011 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL mem: got op=%b ill=%b, expected op=0011 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("mem: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
    @(negedge clk);
    bus.i_ALUOp = 4'b0100; bus.i_funct = 6'b000000;
    @(posedge clk); #1;
    checks++;
    if (bus.o_operation !== 4'b0100 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL branch: got op=%b ill=%b, expected op=0100 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("branch: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
  endtask

  task automatic test_immediate();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.i_ALUOp = im_aluop[i]; bus.i_funct = 6'(i * 11);
      @(posedge clk); #1;
      checks++;
      if (bus.o_operation !== im_op[i] || bus.o_illegal !== 1'b0) begin
        errors++;
        $display("FAIL imm aluop=%b: got op=%b ill=%b, expected op=%b ill=0",
                 im_aluop[i], bus.o_operation, bus.o_illegal, im_op[i]);
      end else begin
        $display("imm aluop=%b: op=%b ill=%b", im_aluop[i], bus.o_operation, bus.o_illegal);
      end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] aluop [6];
    logic [5:0] funct [6];
    aluop[0] = 4'b0000; funct[0] = 6'b111111;
    aluop[1] = 4'b1001; funct[1] = 6'b100100;
    aluop[2] = 4'b0110; funct[2] = 6'b100000;
    aluop[3] = 4'b1011; funct[3] = 6'b000000;
    aluop[4] = 4'b0010; funct[4] = 6'b100101;
    aluop[5] = 4'b0000; funct[5] = 6'b000001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.i_ALUOp = aluop[i]; bus.i_funct = funct[i];
      @(posedge clk); #1;
      checks++;
      if (bus.o_operation !== 4'b0011 || bus.o_illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal aluop=%b funct=%b: got op=%b ill=%b, expected op=0011 ill=1",
                 aluop[i], funct[i], bus.o_operation, bus.o_illegal);
      end else begin
        $display("illegal aluop=%b funct=%b: op=%b ill=%b",
                 aluop[i], funct[i], bus.o_operation, bus.o_illegal);
      end
    end
  endtask

  // Outputs must hold between edges even though the inputs already changed,
  // and an undriven funct must not matter outside the R-type class.
  task automatic test_back_to_back();
    @(negedge clk);
    bus.i_ALUOp = 4'b0001; bus.i_funct = 6'bxxxxxx;
    @(posedge clk); #1;
    checks++;
    if (bus.o_operation !== 4'b0011 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL xfunct_mem: got op=%b ill=%b, expected op=0011 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("xfunct_mem: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
    @(negedge clk);
    bus.i_ALUOp = 4'b1100; bus.i_funct = 6'bzzzzzz;
    #1;
    checks++;
    if (bus.o_operation !== 4'b0011 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL hold: got op=%b ill=%b, expected op=0011 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("hold: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.o_operation !== 4'b0101 || bus.o_illegal !== 1'b0) begin
      errors++;
      $display("FAIL zfunct_imm: got op=%b ill=%b, expected op=0101 ill=0",
               bus.o_operation, bus.o_illegal);
    end else begin
      $display("zfunct_imm: op=%b ill=%b", bus.o_operation, bus.o_illegal);
    end
  endtask

  // One-cycle reset pulse in the middle of an R-type sweep.
  task automatic test_midstream_reset();
    for (int i = 0; i < 6; i++) begin
      logic [3:0] exp_op;
      @(negedge clk);
      rst = (i == 3);
      bus.i_ALUOp = 4'b0000; bus.i_funct = rt_funct[i + 9];
      exp_op = (i == 3) ? 4'b0011 : rt_op[i + 9];
      @(posedge clk); #1;
      checks++;
      if (bus.o_operation !== exp_op || bus.o_illegal !== 1'b0) begin
        errors++;
        $display("FAIL midreset step=%0d rst=%b: got op=%b ill=%b, expected op=%b ill=0",
                 i, rst, bus.o_operation, bus.o_illegal, exp_op);
      end else begin
        $display("midreset step=%0d rst=%b: op=%b ill=%b", i, rst, bus.o_operation, bus.o_illegal);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_ALUOp = 4'b0000;
    bus.i_funct = 6'b000000;
    test_reset();
    test_rtype();
    test_mem_branch();
    test_immediate();
    test_illegal();
    test_back_to_back();
    test_midstream_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog: the sequence is a few dozen cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 Parameters: none; all widths are fixed.
REQ-002 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_ALUOp  input  4  operation class from main control.
REQ-005 i_funct  input  6  instruction funct field; used only when i_ALUOp=0000.
REQ-006 o_operation  output  4  registered ALU operation code.
REQ-007 o_illegal  output  1  registered flag: the last decoded input pair is unsupported.

Function
REQ-008 Operation codes SHALL be: SLL=0000, SRL=0001, SRA=0010, ADD=0011, SUB=0100, AND=0101, OR=0110, XOR=0111, NOR=1000, SLT=1001, LUI=1010, SLLV=1011, SRLV=1100, SRAV=1101; codes 1110 and 1111 are unused.
REQ-009 i_ALUOp=0000 (R-type) SHALL decode i_funct as follows:
 - 100000 and 100001 (ADD, ADDU) -> ADD.
 - 100010 and 100011 (SUB, SUBU) -> SUB.
 - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 101010 SLT.
 - 000000 SLL, 000010 SRL, 000011 SRA, 000100 SLLV, 000110 SRLV, 000111 SRAV.
REQ-010 Any other funct with i_ALUOp=0000 SHALL produce ADD with o_illegal=1.
REQ-011 i_ALUOp=0001 (load/store address) SHALL produce ADD, ignoring i_funct.
REQ-012 i_ALUOp=0100 (branch compare / idle) SHALL produce SUB, ignoring i_funct.
REQ-013 i_ALUOp=1xxx (immediate) SHALL decode i_ALUOp[2:0], ignoring i_funct:
 - 000 ADD, 100 AND, 101 OR, 110 XOR, 111 LUI, 010 SLT.
 - 001 and 011 SHALL produce ADD with o_illegal=1.
REQ-014 All other i_ALUOp values (0010, 0011, 0101, 0110, 0111) SHALL produce ADD with o_illegal=1.
REQ-015 The decode SHALL be purely combinational from the current inputs; both outputs SHALL register the decode result at every rising i_clk edge while i_rst=0.
REQ-016 Latency SHALL be exactly one cycle: inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
REQ-017 There SHALL be no handshake and no enable; a new decode is produced every cycle.
REQ-018 o_illegal SHALL be 0 for every supported encoding listed in REQ-009 to REQ-013.
REQ-019 X or Z on i_funct SHALL NOT affect the outputs when i_ALUOp is not 0000.

Reset
REQ-020 While i_rst=1 at a rising edge, o_operation SHALL load ADD (0011) and o_illegal SHALL load 0, regardless of inputs.
REQ-021 Reset SHALL take priority over decode in the same cycle.
REQ-022 The first decode after reset SHALL appear one edge after i_rst deasserts.
REQ-023 Asserting reset mid-stream SHALL discard the pending decode; no asynchronous path to the outputs SHALL exist.

Structure
REQ-024 The operation codes, R-type funct codes and immediate sub-codes SHALL be named constants in a shared package (alu_pkg), also used by the ALU.
REQ-025 One combinational sub-module, alu_funct_decode (i_funct -> operation, illegal), is natural; the top level adds the i_ALUOp mux and the output register.

Verification
REQ-026 Reset: i_rst=1 with i_ALUOp=0000 and i_funct=100111 -> after the edge, o_operation=0011 and o_illegal=0.
REQ-027 R-type sweep: i_ALUOp=0000 with each of the 15 functs in REQ-009, one per cycle -> the matching code one cycle later (e.g. 000111 -> 1101, 100001 -> 0011).
REQ-028 Load/store and branch: i_ALUOp=0001 with i_funct=100010 -> 0011; i_ALUOp=0100 with i_funct=000000 -> 0100.
REQ-029 Immediates: i_ALUOp=1000, 1100, 1101, 1110, 1111, 1010 -> 0011, 0101, 0110, 0111, 1010, 1001 respectively.
REQ-030 Illegal inputs: i_ALUOp=0000 with i_funct=111111, i_ALUOp=1001, and i_ALUOp=0110 -> o_operation=0011 and o_illegal=1 each.
REQ-031 Mid-stream reset: i_rst pulses for one cycle during the R-type sweep -> the outputs show 0011/0 for that cycle, then resume with the decode of the inputs present after reset.
